// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline hazard controller bus: hazard sources from decode/execute/memory
// toward the controller, and the per-stage hold/bubble controls plus the
// controller's status and performance counters coming back.
interface pipe_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic [4:0]       dec_rs1;
    logic [4:0]       dec_rs2;
    logic             dec_use_rs1;
    logic             dec_use_rs2;
    logic [4:0]       ex_wreg;
    logic             ex_regwrite;
    logic [1:0]       ex_memtoreg;
    logic             br_taken;
    logic             mem_busy;

    logic             pc_keep;
    logic             fetch_keep;
    logic             decode_keep;
    logic             execute_keep;
    logic             memory_keep;
    logic             fetch_nop;
    logic             decode_nop;
    logic             execute_nop;
    logic             pc_redirect;
    logic             wd_error;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // Pipeline datapath side: reports hazard sources, obeys the controls.
    modport master (
        output dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2,
        output ex_wreg, ex_regwrite, ex_memtoreg, br_taken, mem_busy,
        input  pc_keep, fetch_keep, decode_keep, execute_keep, memory_keep,
        input  fetch_nop, decode_nop, execute_nop, pc_redirect,
        input  wd_error, stall_cnt, flush_cnt
    );

    // Hazard controller side.
    modport slave (
        input  dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2,
        input  ex_wreg, ex_regwrite, ex_memtoreg, br_taken, mem_busy,
        output pc_keep, fetch_keep, decode_keep, execute_keep, memory_keep,
        output fetch_nop, decode_nop, execute_nop, pc_redirect,
        output wd_error, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline hazard controller.
// Resolves, in priority order, watchdog trip, memory freeze, taken-branch
// flush and load-use stall into per-stage keep/nop controls. A watchdog
// trips (sticky) when the data memory stays busy for WAIT_LIMIT consecutive
// cycles. Stall and flush performance counters saturate instead of wrapping.
module pipe_hazard_ctrl #(
    parameter int unsigned WAIT_LIMIT = 255,
    parameter int unsigned CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    pipe_hazard_ctrl_if.slave hz
);
    localparam int unsigned     WC_W    = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(WAIT_LIMIT - 1);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_TRIP = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [WC_W-1:0]  wait_cnt;
    logic [WC_W-1:0]  next_wait;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             wd_error;
    logic             load_use;

    logic pc_keep;
    logic fetch_keep;
    logic decode_keep;
    logic execute_keep;
    logic memory_keep;
    logic fetch_nop;
    logic decode_nop;
    logic execute_nop;
    logic pc_redirect;

    // A load in execute whose nonzero destination is read by decode; x0 is
    // hardwired so it can never carry a real dependency.
    assign load_use = hz.ex_regwrite
                   && (hz.ex_memtoreg == 2'b01)
                   && (hz.ex_wreg != 5'd0)
                   && ((hz.dec_use_rs1 && (hz.dec_rs1 == hz.ex_wreg))
                    || (hz.dec_use_rs2 && (hz.dec_rs2 == hz.ex_wreg)));

    // Next state and wait count; wait_cnt holds the number of consecutive busy
    // cycles already seen, including the RUN cycle that entered WAIT.
    always_comb begin
        next_state = state;
        next_wait  = wait_cnt;
        case (state)
            ST_RUN: begin
                next_wait = '0;
                if (hz.mem_busy) begin
                    if (WAIT_LIMIT <= 1) begin
                        next_state = ST_TRIP;
                    end else begin
                        next_state = ST_WAIT;
                        next_wait  = WC_W'(1);
                    end
                end
            end
            ST_WAIT: begin
                if (hz.mem_busy) begin
                    if (wait_cnt == WC_LAST) begin
                        next_state = ST_TRIP;
                    end else if (wait_cnt != '1) begin
                        next_wait = wait_cnt + 1'b1;
                    end
                end else begin
                    next_state = ST_RUN;
                    next_wait  = '0;
                end
            end
            ST_TRIP: begin
                next_state = ST_TRIP;
            end
            default: begin
                next_state = ST_RUN;
                next_wait  = '0;
            end
        endcase
    end

    // Stage controls by priority; forced idle while reset is held so nothing
    // reaches the pipeline registers independent of the clock.
    always_comb begin
        pc_keep      = 1'b0;
        fetch_keep   = 1'b0;
        decode_keep  = 1'b0;
        execute_keep = 1'b0;
        memory_keep  = 1'b0;
        fetch_nop    = 1'b0;
        decode_nop   = 1'b0;
        execute_nop  = 1'b0;
        pc_redirect  = 1'b0;
        if (rst) begin
            if ((state == ST_TRIP) || hz.mem_busy) begin
                pc_keep      = 1'b1;
                fetch_keep   = 1'b1;
                decode_keep  = 1'b1;
                execute_keep = 1'b1;
                memory_keep  = 1'b1;
            end else if (hz.br_taken) begin
                fetch_nop   = 1'b1;
                decode_nop  = 1'b1;
                execute_nop = 1'b1;
                pc_redirect = 1'b1;
            end else if (load_use) begin
                pc_keep    = 1'b1;
                fetch_keep = 1'b1;
                decode_nop = 1'b1;
            end
        end
    end

    // State and wait counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
        end else begin
            state    <= next_state;
            wait_cnt <= next_wait;
        end
    end

    // Sticky watchdog flag, raised on the transition into TRIP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_error <= 1'b0;
        end else if ((next_state == ST_TRIP) && (state != ST_TRIP)) begin
            wd_error <= 1'b1;
        end
    end

    // Saturating stall and flush counters; a tripped pipeline is not stalling.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (pc_keep && (state != ST_TRIP) && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (pc_redirect && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

    assign hz.pc_keep      = pc_keep;
    assign hz.fetch_keep   = fetch_keep;
    assign hz.decode_keep  = decode_keep;
    assign hz.execute_keep = execute_keep;
    assign hz.memory_keep  = memory_keep;
    assign hz.fetch_nop    = fetch_nop;
    assign hz.decode_nop   = decode_nop;
    assign hz.execute_nop  = execute_nop;
    assign hz.pc_redirect  = pc_redirect;
    assign hz.wd_error     = wd_error;
    assign hz.stall_cnt    = stall_cnt;
    assign hz.flush_cnt    = flush_cnt;
endmodule
